demux_1t8_32_buf: RTL

Registered 1-to-8 32-bit demultiplexer: the write-side counterpart of the 8-to-1 32-bit result mux. It steers one 32-bit input word to one of eight output lanes selected by `sel`. Each lane holds the word in a one-entry buffer until its consumer accepts it. It sits between a single result producer (ALU/datapath) and up to eight independent consumers, with valid/ready flow control on every side.

---
 rtl/demux_1t8_32_buf_pkg.sv | 9 +
 rtl/demux_lane_32.sv | 53 +++++
 rtl/demux_1t8_32_buf.sv | 74 +++++++
 3 files changed

// File: rtl/demux_1t8_32_buf_pkg.sv
// Package shared by the 1-to-8 32-bit buffered demultiplexer.
// Holds the datapath width, the lane count and the lane-select width.
package demux_1t8_32_buf_pkg;

    localparam int unsigned ALU_WIDTH   = 32;
    localparam int unsigned DEMUX_LANES = 8;
    localparam int unsigned DEMUX_SEL_W = 3;

endpackage : demux_1t8_32_buf_pkg

// File: rtl/demux_lane_32.sv
// One-entry output buffer for a single demux lane.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset (clears data and valid)
//   load  - store d this cycle (already qualified by the accept and the lane decode)
//   d     - incoming data word
//   ready - consumer takes the held word this cycle
//   q     - held data word (registered, not cleared on drain)
//   valid - buffer holds a word
module demux_lane_32
    import demux_1t8_32_buf_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // A load takes priority over a drain: the drained word leaves and the
    // new word lands in the same cycle, so valid stays set.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = d;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule : demux_lane_32

// File: rtl/demux_1t8_32_buf.sv
// Registered 1-to-8 32-bit demultiplexer with a one-entry buffer per lane.
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   x, sel, in_valid  - producer word, destination lane and valid
//   in_ready          - combinational: the lane addressed by sel can take a word
//   q0..q7            - registered lane data
//   out_valid         - bit i set while lane i holds a word
//   out_ready         - bit i: consumer i takes lane i this cycle
//   busy              - any lane holds a word
module demux_1t8_32_buf
    import demux_1t8_32_buf_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned LANES = DEMUX_LANES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       x,
    input  logic [DEMUX_SEL_W-1:0] sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       q0,
    output logic [WIDTH-1:0]       q1,
    output logic [WIDTH-1:0]       q2,
    output logic [WIDTH-1:0]       q3,
    output logic [WIDTH-1:0]       q4,
    output logic [WIDTH-1:0]       q5,
    output logic [WIDTH-1:0]       q6,
    output logic [WIDTH-1:0]       q7,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic                   busy
);

    logic             acc;
    logic [LANES-1:0] load_vec;
    logic [WIDTH-1:0] lane_q [LANES];

    // Readiness only looks at the addressed lane; a full lane draining this
    // cycle still accepts (pass-through).
    assign in_ready = !out_valid[sel] || out_ready[sel];
    assign acc      = in_valid && in_ready;

    always_comb begin
        load_vec = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            load_vec[i] = acc && (sel == DEMUX_SEL_W'(i));
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        demux_lane_32 #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .load  (load_vec[i]),
            .d     (x),
            .ready (out_ready[i]),
            .q     (lane_q[i]),
            .valid (out_valid[i])
        );
    end

    assign busy = |out_valid;

    assign q0 = lane_q[0];
    assign q1 = lane_q[1];
    assign q2 = lane_q[2];
    assign q3 = lane_q[3];
    assign q4 = lane_q[4];
    assign q5 = lane_q[5];
    assign q6 = lane_q[6];
    assign q7 = lane_q[7];

endmodule : demux_1t8_32_buf
